// File: rtl/sdp_ram_rd_stream.sv
// Streams a burst of words out of a simple-dual-port RAM read port into a ready/valid stream.
// Optional macro SDP_RD_STREAM_LAST_EN adds an m_last output marking the final word of a burst.
module sdp_ram_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 1024,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef SDP_RD_STREAM_LAST_EN
  output logic                  m_last,
`endif
  input  logic                  m_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [AW-1:0]         addr;
  logic [AW:0]           remaining;
  logic                  inflight;
  logic                  done_q;
  logic [1:0]            count;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [DATA_WIDTH-1:0] buf_mem [0:2];

  logic pop;
  logic credit_ok;
  logic issue;
  logic final_pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read may issue only if its word is guaranteed a free slot on arrival:
  // occupancy + reads in flight must stay below 3, counting this cycle's pop as a freed slot.
  always_comb begin
    pop       = m_valid && m_ready;
    credit_ok = ({1'b0, count} + {2'b00, inflight}) < (3'd3 + {2'b00, pop});
    issue     = (state == S_RUN) && credit_ok && !rst;
    final_pop = (state == S_DRAIN) && pop && (count == 2'd1) && !inflight;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      done_q   <= 1'b0;
      inflight <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= len;
            if (len == '0) done_q <= 1'b1;
            else           state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            addr      <= (addr == AW'(DATA_DEPTH - 1)) ? '0 : addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (AW+1)'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (final_pop) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (inflight) wr_ptr <= ptr_next(wr_ptr);
      if (pop)      rd_ptr <= ptr_next(rd_ptr);
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // NOTE: buffer storage is deliberately not reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (inflight) buf_mem[wr_ptr] <= ram_rd_data;
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = done_q;
    ram_rd_en   = issue;
    ram_rd_addr = addr;
    m_valid     = (count != 2'd0);
    m_data      = m_valid ? buf_mem[rd_ptr] : '0;
  end

`ifdef SDP_RD_STREAM_LAST_EN
  // Only the newest word can be the last, so it is the head once it is alone and nothing is pending.
  assign m_last = (state == S_DRAIN) && (count == 2'd1) && !inflight;
`endif

endmodule

// File: tb/tb_sdp_ram_rd_stream.sv
// Directed bench for sdp_ram_rd_stream against a behavioural RAM preloaded with mem[i] = i.
// Builds with or without SDP_RD_STREAM_LAST_EN.
module tb_sdp_ram_rd_stream;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef SDP_RD_STREAM_LAST_EN
  logic          m_last;
`endif

  sdp_ram_rd_stream #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .m_valid(m_valid), .m_data(m_data),
`ifdef SDP_RD_STREAM_LAST_EN
    .m_last(m_last),
`endif
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  int total = 0;
  int bad   = 0;

  // Per-burst observations filled by run_burst
  int q_addr[$];
  int q_data[$];
  int first_rd, first_valid, done_cycle, rd_count, max_out;
  int busy_err, hold_err, done_extra, last_cnt, last_err;

  // Returns -1 when q holds exactly n words (start+i) mod DEPTH, else the first bad index
  function automatic int seq_diff(input int q[$], input int start_v, input int n);
    if (q.size() != n) return q.size();
    for (int i = 0; i < n; i++)
      if (q[i] != ((start_v + i) % DEPTH)) return i;
    return -1;
  endfunction

  task automatic run_burst(input int base, input int blen, input int stall_lo,
                           input int stall_hi, input int restart_cyc);
    int issued = 0;
    int delivered = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit seen_done = 0;
    q_addr.delete(); q_data.delete();
    first_rd = -1; first_valid = -1; done_cycle = -1; rd_count = 0; max_out = 0;
    busy_err = 0; hold_err = 0; done_extra = 0; last_cnt = 0; last_err = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); len = (AW+1)'(blen);
    m_ready = !(stall_lo <= 0 && 0 <= stall_hi);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ram_rd_en) begin
        if (first_rd < 0) first_rd = c;
        q_addr.push_back(int'(ram_rd_addr));
        issued++;
      end
      if (m_valid && first_valid < 0) first_valid = c;
      if (prev_stall && (!m_valid || m_data !== prev_data)) hold_err++;
      if (m_valid && m_ready) begin
        q_data.push_back(int'(m_data));
        delivered++;
      end
      if (issued - delivered > max_out) max_out = issued - delivered;
      if (busy !== ((c >= 1) && !seen_done && !done && blen != 0)) busy_err++;
`ifdef SDP_RD_STREAM_LAST_EN
      if (m_last && !m_valid) last_err++;
      if (m_valid && m_ready && m_last) begin
        last_cnt++;
        if (int'(m_data) != (base + blen - 1) % DEPTH) last_err++;
      end
`endif
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (seen_done) begin
        if (done) done_extra++;
        break;
      end
      if (done) begin
        done_cycle = c;
        seen_done = 1;
      end
      @(posedge clk); #1;
      start = ((c + 1) == restart_cyc);
      if (start) begin base_addr = AW'(500); len = (AW+1)'(2); end
      m_ready = !(stall_lo <= c + 1 && c + 1 <= stall_hi);
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, ram_rd_en, m_valid} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, ram_rd_en, m_valid});
    end
    total++;
    if (ram_rd_addr !== '0 || m_data !== '0) begin
      bad++; $display("FAIL reset_data addr=%0d data=%0d exp=0/0", ram_rd_addr, m_data);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    run_burst(5, 4, -1, -1, -1);
    total++;
    if (first_rd != 1) begin bad++; $display("FAIL basic_rd_lat got=%0d exp=1", first_rd); end
    total++;
    if (first_valid != 3) begin bad++; $display("FAIL basic_valid_lat got=%0d exp=3", first_valid); end
    d = seq_diff(q_data, 5, 4);
    total++;
    if (d != -1) begin bad++; $display("FAIL basic_data at=%0d got_n=%0d exp_n=4", d, q_data.size()); end
    d = seq_diff(q_addr, 5, 4);
    total++;
    if (d != -1) begin bad++; $display("FAIL basic_addr at=%0d got_n=%0d exp_n=4", d, q_addr.size()); end
    total++;
    if (done_cycle != 7) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=7", done_cycle); end
    total++;
    if (done_extra != 0 || busy_err != 0) begin
      bad++; $display("FAIL basic_done_busy extra=%0d busy_err=%0d exp=0/0", done_extra, busy_err);
    end
`ifdef SDP_RD_STREAM_LAST_EN
    total++;
    if (last_cnt != 1 || last_err != 0) begin
      bad++; $display("FAIL basic_last cnt=%0d err=%0d exp=1/0", last_cnt, last_err);
    end
`endif
  endtask

  task automatic test_wrap();
    int d;
    run_burst(1022, 4, -1, -1, -1);
    d = seq_diff(q_addr, 1022, 4);
    total++;
    if (d != -1) begin bad++; $display("FAIL wrap_addr at=%0d got_n=%0d exp_n=4", d, q_addr.size()); end
    d = seq_diff(q_data, 1022, 4);
    total++;
    if (d != -1) begin bad++; $display("FAIL wrap_data at=%0d got_n=%0d exp_n=4", d, q_data.size()); end
  endtask

  task automatic test_backpressure();
    int d;
    run_burst(0, 8, 4, 9, -1);
    d = seq_diff(q_data, 0, 8);
    total++;
    if (d != -1) begin bad++; $display("FAIL bp_data at=%0d got_n=%0d exp_n=8", d, q_data.size()); end
    total++;
    if (rd_count != 8 && q_addr.size() != 8) begin
      bad++; $display("FAIL bp_reads got=%0d exp=8", q_addr.size());
    end
    total++;
    if (max_out != 3) begin bad++; $display("FAIL bp_outstanding got=%0d exp=3", max_out); end
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    total++;
    if (done_cycle < 0 || done_extra != 0 || busy_err != 0) begin
      bad++; $display("FAIL bp_done cyc=%0d extra=%0d busy_err=%0d", done_cycle, done_extra, busy_err);
    end
`ifdef SDP_RD_STREAM_LAST_EN
    total++;
    if (last_cnt != 1 || last_err != 0) begin
      bad++; $display("FAIL bp_last cnt=%0d err=%0d exp=1/0", last_cnt, last_err);
    end
`endif
  endtask

  task automatic test_zero_len();
    run_burst(7, 0, -1, -1, -1);
    total++;
    if (q_addr.size() != 0) begin bad++; $display("FAIL zero_reads got=%0d exp=0", q_addr.size()); end
    total++;
    if (done_cycle != 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cycle); end
    total++;
    if (busy_err != 0 || q_data.size() != 0) begin
      bad++; $display("FAIL zero_busy busy_err=%0d words=%0d exp=0/0", busy_err, q_data.size());
    end
  endtask

  task automatic test_mid_reset();
    int d;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(100); len = (AW+1)'(16); m_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== DW'(100)) begin
      bad++; $display("FAIL mrst_pre valid=%b data=%0d exp=1/100", m_valid, m_data);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, busy, ram_rd_en} !== 3'b000 || m_data !== '0) begin
      bad++; $display("FAIL mrst_post vbr=%b data=%0d exp=000/0", {m_valid, busy, ram_rd_en}, m_data);
    end
    run_burst(200, 3, -1, -1, -1);
    d = seq_diff(q_data, 200, 3);
    total++;
    if (d != -1 || first_valid != 3) begin
      bad++; $display("FAIL mrst_restart at=%0d first_valid=%0d exp=-1/3", d, first_valid);
    end
  endtask

  task automatic test_start_while_busy();
    int d;
    run_burst(10, 5, -1, -1, 2);
    d = seq_diff(q_data, 10, 5);
    total++;
    if (d != -1) begin bad++; $display("FAIL busy_start_data at=%0d got_n=%0d exp_n=5", d, q_data.size()); end
    d = seq_diff(q_addr, 10, 5);
    total++;
    if (d != -1) begin bad++; $display("FAIL busy_start_addr at=%0d got_n=%0d exp_n=5", d, q_addr.size()); end
    total++;
    if (done_cycle != 8 || done_extra != 0) begin
      bad++; $display("FAIL busy_start_done cyc=%0d extra=%0d exp=8/0", done_cycle, done_extra);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_mid_reset();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdp_ram_rd_stream.md
SDP_RAM_RD_STREAM -- requirements
Module: sdp_ram_rd_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning RAM word width in bits.
REQ-002 The block SHALL have parameter DATA_DEPTH, default 1024, meaning RAM word count; AW = $clog2(DATA_DEPTH).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 The block SHALL have port base_addr  input  AW  first read address, sampled with start.
REQ-007 The block SHALL have port len  input  AW+1  burst length in words (0..DATA_DEPTH), sampled with start.
REQ-008 The block SHALL have port busy  output  1  high from the cycle after start until done.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port ram_rd_en  output  1  read enable to the dual-port RAM read port.
REQ-011 The block SHALL have port ram_rd_addr  output  AW  read address to the RAM.
REQ-012 The block SHALL have port ram_rd_data  input  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_en.
REQ-013 The block SHALL have port m_valid  output  1  stream data valid.
REQ-014 The block SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-015 The block SHALL have port m_ready  input  1  downstream accept.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-017 In IDLE, start=1 SHALL latch base_addr/len and enter RUN; if len=0 it SHALL return to IDLE with done=1 the next cycle and issue no reads.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 In RUN, ram_rd_en SHALL assert when credit>0, where credit = 3 - buffer occupancy - reads in flight + (m_valid && m_ready).
REQ-020 Each issued read SHALL increment the address modulo DATA_DEPTH, wrapping DATA_DEPTH-1 -> 0.
REQ-021 After len reads are issued, the FSM SHALL enter DRAIN and SHALL NOT assert ram_rd_en again.
REQ-022 ram_rd_data SHALL be captured one cycle after its ram_rd_en into a 3-entry in-order output buffer.
REQ-023 m_valid SHALL be high whenever the buffer is non-empty; m_data is the head entry; a transfer occurs on m_valid && m_ready.
REQ-024 m_valid/m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-025 The buffer SHALL never overflow; the credit rule guarantees it.
REQ-026 Latency: start at cycle 0 -> ram_rd_en at cycle 1 -> m_valid at cycle 3.
REQ-027 With m_ready held high, throughput SHALL be one word per cycle.
REQ-028 In DRAIN, the final word's transfer SHALL return the FSM to IDLE, with done=1 for exactly the following cycle.
REQ-029 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE.

Reset
REQ-030 rst=1 SHALL force IDLE, empty the buffer and discard in-flight reads, including mid-burst.
REQ-031 Under rst, busy, done, ram_rd_en, ram_rd_addr and m_valid SHALL be 0; m_data SHALL be 0.

Configuration
REQ-032 Macro SDP_RD_STREAM_LAST_EN defined SHALL add port m_last  output  1, high with m_valid on the burst's final word and 0 otherwise (0 under reset).
REQ-033 Without SDP_RD_STREAM_LAST_EN, port m_last SHALL NOT exist and behaviour is otherwise identical.

Verification
REQ-034 RAM preloaded mem[i]=i; base=5, len=4, m_ready=1 -> m_data 5,6,7,8 on cycles 3..6, done at cycle 7, m_last only on word 8 if enabled.
REQ-035 base=1022, len=4, DATA_DEPTH=1024 -> ram_rd_addr 1022,1023,0,1; data 1022,1023,0,1.
REQ-036 len=8, m_ready low cycles 4..9 -> no word lost or duplicated; ram_rd_en stalls with at most 3 outstanding words; all 8 words are delivered in order.
REQ-037 len=0 -> no ram_rd_en; done at cycle 1; busy stays 0.
REQ-038 rst pulsed at cycle 4 of a len=16 burst -> next cycle m_valid=0, busy=0; a new start afterwards streams correctly from its own base.
REQ-039 start re-asserted while busy -> ignored; the original burst completes unchanged.
